// File: rtl/uart_rx.sv
// 8N1 UART receiver with a small receive FIFO behind a two-register CPU port.
// Data register reads pop the head byte; status register reports and clears the sticky errors.
`timescale 1ns/1ps
module uart_rx #(
  parameter int          BIT_TMR_MAX    = 10416,
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [63:0] RX_DATA_ADDR   = 64'h0000_0000_4000_0010,
  parameter logic [63:0] RX_STATUS_ADDR = 64'h0000_0000_4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        valid,
  input  logic [63:0] addr,
  input  logic        wvalid,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        ready
);

  localparam int TMR_W = (BIT_TMR_MAX < 2) ? 1 : $clog2(BIT_TMR_MAX + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(BIT_TMR_MAX);
  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(BIT_TMR_MAX / 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic             rx_meta_r;
  logic             rx_s;
  state_t           state_r;
  logic [TMR_W-1:0] tmr_r;
  logic [2:0]       idx_r;
  logic [7:0]       shift_r;
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             frame_err_r;
  logic             overrun_r;

  logic stop_smp_s, push_s, frame_set_s;
  logic full_s, nonempty_s, pop_s, wr_en_s, ovr_set_s, stat_wr_s;
  logic unused_s;

  assign stop_smp_s  = (state_r == STOP) && (tmr_r == TMR_FULL);
  assign push_s      = stop_smp_s && rx_s;
  assign frame_set_s = stop_smp_s && !rx_s;
  assign full_s      = (cnt_r == CNT_FULL);
  assign nonempty_s  = (cnt_r != {CNT_W{1'b0}});
  assign pop_s       = valid && !wvalid && (addr == RX_DATA_ADDR) && nonempty_s;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en_s     = push_s && (!full_s || pop_s);
  assign ovr_set_s   = push_s && full_s && !pop_s;
  assign stat_wr_s   = valid && wvalid && (addr == RX_STATUS_ADDR);
  assign ready       = 1'b1;
  assign unused_s    = ^{wdata[63:4], wdata[1:0]};

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s      <= rx_meta_r;
    end
  end

  // Receive FSM: start-bit qualification at mid-bit, then one sample per bit period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      tmr_r   <= {TMR_W{1'b0}};
      idx_r   <= 3'd0;
      shift_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_r <= START;
            tmr_r   <= {TMR_W{1'b0}};
          end
        end
        START: begin
          if (tmr_r == TMR_HALF) begin
            tmr_r <= {TMR_W{1'b0}};
            if (!rx_s) begin
              state_r <= DATA;
              idx_r   <= 3'd0;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            tmr_r <= tmr_r + TMR_W'(1);
          end
        end
        DATA: begin
          if (tmr_r == TMR_FULL) begin
            shift_r[idx_r] <= rx_s;
            tmr_r          <= {TMR_W{1'b0}};
            idx_r          <= idx_r + 3'd1;
            if (idx_r == 3'd7) begin
              state_r <= STOP;
            end
          end else begin
            tmr_r <= tmr_r + TMR_W'(1);
          end
        end
        STOP: begin
          if (tmr_r == TMR_FULL) begin
            state_r <= IDLE;
            tmr_r   <= {TMR_W{1'b0}};
          end else begin
            tmr_r <= tmr_r + TMR_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          tmr_r   <= {TMR_W{1'b0}};
        end
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= shift_r;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({wr_en_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Sticky error flags; a set event beats a same-cycle write-1-to-clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= frame_set_s | (frame_err_r & ~(stat_wr_s & wdata[2]));
      overrun_r   <= ovr_set_s   | (overrun_r   & ~(stat_wr_s & wdata[3]));
    end
  end

  // Combinational read mux
  always_comb begin
    rdata = 64'd0;
    if (valid && !wvalid) begin
      if (addr == RX_DATA_ADDR) begin
        if (nonempty_s) begin
          rdata = {56'd0, mem_r[rd_ptr_r]};
        end else begin
          rdata = 64'd0;
        end
      end else if (addr == RX_STATUS_ADDR) begin
        rdata = {60'd0, overrun_r, frame_err_r, full_s, nonempty_s};
      end else begin
        rdata = 64'd0;
      end
    end else begin
      rdata = 64'd0;
    end
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BIT_TMR_MAX, default 10416, giving one bit period of BIT_TMR_MAX+1 clk cycles.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, a power of two and at least 2, giving the receive FIFO depth in bytes.
REQ-003 SHALL have parameter RX_DATA_ADDR, default 64'h0000_0000_4000_0010, the read-and-pop data register.
REQ-004 SHALL have parameter RX_STATUS_ADDR, default 64'h0000_0000_4000_0018, the status and clear register.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port rx, input, 1 bit: asynchronous serial line, idles high, 8N1, LSB first.
REQ-008 SHALL have port valid, input, 1 bit: CPU access strobe.
REQ-009 SHALL have port addr, input, 64 bits: access address.
REQ-010 SHALL have port wvalid, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port wdata, input, 64 bits: write data.
REQ-012 SHALL have port rdata, output, 64 bits: combinational read data.
REQ-013 SHALL have port ready, output, 1 bit: access complete; tied to 1.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer (rx_s), both flops resetting to 1.
REQ-015 SHALL implement the states IDLE, START, DATA and STOP with a bit timer (0..BIT_TMR_MAX) and a 3-bit bit index.
REQ-016 SHALL move IDLE->START with timer=0 in the cycle after rx_s==0 is seen in IDLE.
REQ-017 SHALL check rx_s in START when timer==BIT_TMR_MAX/2 (integer division): if rx_s==0, go to DATA with timer=0 and index=0; else return to IDLE with no flag change (glitch rejection).
REQ-018 SHALL, in DATA when timer==BIT_TMR_MAX, load rx_s into shift[index], clear timer and increment index; after index 7 is sampled, go to STOP.
REQ-019 SHALL, in STOP when timer==BIT_TMR_MAX, push the byte if rx_s==1; if rx_s==0, set sticky frame_err, discard the byte and do not push; in both cases go to IDLE.
REQ-020 SHALL, on a push while the FIFO is full and no pop occurs in the same cycle, drop the byte, set sticky overrun and leave the FIFO unchanged.
REQ-021 SHALL define a pop as valid && !wvalid && addr==RX_DATA_ADDR in a cycle while the FIFO is non-empty; each such cycle pops exactly once.
REQ-022 SHALL, on a read of RX_DATA_ADDR, drive rdata = {56'b0, head byte} in the same cycle; when the FIFO is empty, rdata = 0 and no pop occurs.
REQ-023 SHALL drive rdata = {60'b0, overrun, frame_err, full, nonempty} (bit0 = nonempty) on a read of RX_STATUS_ADDR.
REQ-024 SHALL drive rdata = 0 for all other addresses, or when valid==0.
REQ-025 SHALL, on a write to RX_STATUS_ADDR, clear frame_err if wdata[2]==1 and clear overrun if wdata[3]==1; other bits are ignored.
REQ-026 SHALL let a set event win over a write-1-to-clear of the same flag in the same cycle.
REQ-027 SHALL ignore writes to RX_DATA_ADDR.
REQ-028 SHALL, on a push and pop in the same cycle: keep the count unchanged, accept the pushed byte, and set no overrun, including when the FIFO is full.
REQ-029 SHALL wrap FIFO pointers modulo FIFO_DEPTH and keep a count from 0 to FIFO_DEPTH; full = (count==FIFO_DEPTH), nonempty = (count!=0).
REQ-030 SHALL make a pushed byte visible at RX_DATA_ADDR from the cycle after the push.

Reset
REQ-031 SHALL, while reset==1, force the state to IDLE, clear timer, index, shift, FIFO pointers, count, frame_err and overrun, and set the synchronizer flops to 1.
REQ-032 SHALL, on reset asserted mid-frame, discard the partial byte with no push; after release, wait for a new falling edge.
REQ-033 SHALL hold ready = 1 and rdata = 0 in reset when valid==0.

Verification (BIT_TMR_MAX=15, FIFO_DEPTH=4)
REQ-034 SHALL cover: frame 0x48 (start 0, bits LSB first, stop 1, 16 cycles per bit) -> status reads 0x1; RX_DATA reads 0x48; status then reads 0x0.
REQ-035 SHALL cover: rx low for 4 cycles, then high -> no push, status stays 0x0, state back to IDLE.
REQ-036 SHALL cover: byte 0x55 with stop bit 0 -> no push, status reads 0x4; write 0x4 to RX_STATUS_ADDR -> status reads 0x0.
REQ-037 SHALL cover: 5 frames 0x01..0x05 with no reads -> status 0xB; reads return 0x01, 0x02, 0x03, 0x04, then 0x00.
REQ-038 SHALL cover: FIFO full, 5th stop-bit sample coinciding with an RX_DATA read -> read returns 0x01, no overrun, later reads return 0x02..0x05.
REQ-039 SHALL cover: reset pulse during data bit 4 of 0xA5 -> FIFO empty, status 0x0; the next full frame 0x3C reads back as 0x3C.
